z80_bus_responder: RTL
======================

# z80_bus_responder

Synchronous memory/IO responder for the far end of the tv80s bus. It decodes CPU bus cycles (memory read/write, IO read/write, interrupt acknowledge) and serves them from a 64 KiB byte array. The IO window is mapped onto that array and is configurable by parameter. It stretches cycles with configurable wait states, and gives the bench a handshaked backdoor load port. It replaces ad-hoc bench memory models in CPU-level instruction tests.

## Interface
- `IO_PAGE`, default 8'h10: IO accesses map to array address {IO_PAGE, A[7:0]}.
- `MEM_WAIT`, default 0: wait cycles inserted on memory read/write (0..15).
- `IO_WAIT`, default 1: wait cycles inserted on IO read/write (0..15).
- `RESET_DI`, default 8'hFF: value of `di` after reset.
- `clk`, input, 1: CPU clock; all state on rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n`, inputs, 1 each: tv80s bus strobes, active low.
- `A`, input, 16: CPU address.
- `dout`, input, 8: CPU write data.
- `di`, output, 8: read data to CPU, registered.
- `wait_n`, output, 1: registered; low stretches the CPU cycle.
- `int_vec`, input, 8: byte returned on interrupt acknowledge.
- `ld_req`, input, 1: backdoor write request.
- `ld_addr`, input, 16: backdoor write address.
- `ld_data`, input, 8: backdoor write data.
- `ld_ack`, output, 1: one-cycle pulse when the backdoor write commits.
- `acc_cnt`, output, 16: count of completed bus accesses; wraps.

## Operation
- Request decode is sampled at the rising edge while in IDLE. Priority order:
  - INTA: m1_n=0 & iorq_n=0.
  - IO: iorq_n=0 & m1_n=1 & (rd_n=0 | wr_n=0).
  - MEM: mreq_n=0 & rfsh_n=1 & (rd_n=0 | wr_n=0).
  - Refresh (rfsh_n=0) is never a request.
  - If rd_n and wr_n are both low, the cycle is a write.
- FSM states: IDLE, WAIT, ACCESS, RELEASE.
  - IDLE → WAIT when a request is decoded and its wait count W>0. The wait counter loads W-1.
  - IDLE → ACCESS when a request is decoded and W=0. INTA always uses W=0.
  - WAIT: wait_n=0. Counter decrements each cycle; → ACCESS when the counter is 0.
  - ACCESS (one cycle):
    - Read: di ← mem[addr].
    - Write: mem[addr] ← dout, with dout sampled at this edge.
    - INTA: di ← int_vec.
    - acc_cnt increments.
    - → RELEASE.
  - RELEASE: → IDLE once mreq_n=1 & iorq_n=1, so that one strobe assertion yields exactly one access. Refresh cycles with mreq_n=0 & rfsh_n=0 also allow the return to IDLE.
- Address: MEM uses A; IO uses {IO_PAGE, A[7:0]}; the decoded address is latched on entry from IDLE.
- Backdoor load:
  - Commits only in IDLE when no bus request is decoded that cycle: mem[ld_addr] ← ld_data, with ld_ack=1 for the next cycle.
  - Otherwise the request is held pending; the requester keeps ld_req/ld_addr/ld_data stable until ld_ack.
  - A bus request in the same cycle always wins.
- Reset (reset_n=0 at an edge):
  - State → IDLE; wait_n=1, di=RESET_DI, ld_ack=0, acc_cnt=0.
  - Array contents retained.
  - Reset mid-WAIT or mid-ACCESS aborts the access with no array write.

## Timing
- A request sampled at edge N with W waits:
  - wait_n=0 from after N to after N+W.
  - The ACCESS edge is N+W+1.
  - di is valid after edge N+W+1 and holds until the next read or INTA access.
- W=0: wait_n never drops; data is valid one clock after the request is sampled.
- di and wait_n are glitch-free register outputs; there is no combinational path from inputs to outputs.
- acc_cnt wraps 16'hFFFF → 16'h0000.

## Test plan
- Opcode fetch:
  - Stimulus: backdoor-load mem[0000]=8'h27 (DAA); run tv80s from reset with A=9A, F=02.
  - Required response:
    - Fetch returns 27.
    - After 4 clocks the CPU holds A=34, F=23, PC=0001, R=01.
    - acc_cnt=1.
- Memory write:
  - Stimulus: LD (8000),A with A=5C, MEM_WAIT=2.
  - Required response: wait_n low for exactly 2 cycles in the write cycle; mem[8000]=5C; acc_cnt=4.
- IO read:
  - Stimulus: mem[1042]=A5; IN A,(42) with IO_WAIT=1.
  - Required response: wait_n low for 1 cycle; A=A5; array address used is 1042.
- Interrupt acknowledge:
  - Stimulus: force m1_n=0, iorq_n=0 with int_vec=FF.
  - Required response: di=FF one cycle later; no wait.
- Backdoor collision:
  - Stimulus: assert ld_req (addr 0100, data 77) in the same cycle as a MEM read decode.
  - Required response: ld_ack delayed until the FSM returns to IDLE; mem[0100]=77 afterwards; the read data is unaffected.
- Reset mid-wait:
  - Stimulus: drop reset_n during WAIT of a write to 2000 (old value 11).
  - Required response: wait_n=1 and di=FF on the next edge; mem[2000] stays 11; acc_cnt=0.

Source files
------------

// File: rtl/z80_bus_responder.sv
// tv80s-side bus responder: serves memory, IO and interrupt-acknowledge cycles from a 64 KiB
// byte array, with parameterised wait states and a handshaked backdoor load port.
module z80_bus_responder #(
   parameter logic [7:0]  IO_PAGE  = 8'h10,
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 1,
   parameter logic [7:0]  RESET_DI = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   output logic [7:0]  di,
   output logic        wait_n,
   input  logic [7:0]  int_vec,
   input  logic        ld_req,
   input  logic [15:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic        ld_ack,
   output logic [15:0] acc_cnt
);

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StRelease} state_e;
   typedef enum logic [1:0] {KindRead, KindWrite, KindInta} kind_e;

   localparam logic [3:0] MemWaitCnt = 4'(MEM_WAIT);
   localparam logic [3:0] IoWaitCnt  = 4'(IO_WAIT);

   logic [7:0] mem [65536];

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  di_q;
   logic        wait_n_q, wait_n_d;
   logic        ld_ack_q, ld_ack_d;
   logic [15:0] acc_cnt_q, acc_cnt_d;

   logic        req_inta, req_io, req_mem, req;
   logic [3:0]  req_wait;
   logic        di_ld_mem, di_ld_vec;
   logic        mem_we;
   logic [15:0] mem_waddr;
   logic [7:0]  mem_wdata;

   always_comb begin
      req_inta = ~m1_n & ~iorq_n;
      req_io   = ~iorq_n & m1_n & (~rd_n | ~wr_n);
      req_mem  = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
      req      = req_inta | req_io | req_mem;
   end

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      acc_cnt_d = acc_cnt_q;
      ld_ack_d  = 1'b0;
      req_wait  = 4'd0;
      di_ld_mem = 1'b0;
      di_ld_vec = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = dout;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (req_inta) begin
                  kind_d   = KindInta;
                  req_wait = 4'd0;
               end else if (req_io) begin
                  kind_d   = wr_n ? KindRead : KindWrite;
                  addr_d   = {IO_PAGE, A[7:0]};
                  req_wait = IoWaitCnt;
               end else begin
                  kind_d   = wr_n ? KindRead : KindWrite;
                  addr_d   = A;
                  req_wait = MemWaitCnt;
               end
               if (req_wait == 4'd0) begin
                  state_d = StAccess;
               end else begin
                  state_d = StWait;
                  cnt_d   = req_wait - 4'd1;
               end
            end else if (ld_req && !ld_ack_q) begin
               // ld_ack_q blocks a second commit while the requester is still seeing the ack
               mem_we    = 1'b1;
               mem_waddr = ld_addr;
               mem_wdata = ld_data;
               ld_ack_d  = 1'b1;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StAccess;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StAccess: begin
            acc_cnt_d = acc_cnt_q + 16'd1;
            state_d   = StRelease;
            unique case (kind_q)
               KindRead:  di_ld_mem = 1'b1;
               KindWrite: mem_we    = 1'b1;
               KindInta:  di_ld_vec = 1'b1;
               default:   ;
            endcase
         end
         StRelease: begin
            // Wait for the strobes to drop so one assertion yields exactly one access
            if ((mreq_n & iorq_n) | (~mreq_n & ~rfsh_n)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      wait_n_d = (state_d != StWait);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         kind_q    <= KindRead;
         cnt_q     <= 4'd0;
         addr_q    <= 16'd0;
         di_q      <= RESET_DI;
         wait_n_q  <= 1'b1;
         ld_ack_q  <= 1'b0;
         acc_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wait_n_q  <= wait_n_d;
         ld_ack_q  <= ld_ack_d;
         acc_cnt_q <= acc_cnt_d;
         if (di_ld_mem) begin
            di_q <= mem[addr_q];
         end else if (di_ld_vec) begin
            di_q <= int_vec;
         end
      end
   end

   // Array has no reset; gating on reset_n drops writes aborted by reset
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign di      = di_q;
   assign wait_n  = wait_n_q;
   assign ld_ack  = ld_ack_q;
   assign acc_cnt = acc_cnt_q;

endmodule
